// File: rtl/miner_nonce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : miner_nonce_scheduler
// Description : Walks a nonce range through the miner core, compares each
//               digest with the target and stops on the first hit or when the
//               range is exhausted. Optional macro: MINER_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module miner_nonce_scheduler #(
  parameter int unsigned WDOG_CYCLES = 400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  input  logic         finished,
  input  logic [255:0] digest,
  output logic         hash_enable,
  output logic [31:0]  nonce,
  output logic         busy,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic         done,
  output logic [31:0]  hash_count,
  output logic [7:0]   retries
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT      = 3'd2,
    CHECK     = 3'd3,
    FOUND     = 3'd4,
    EXHAUSTED = 3'd5
  } state_t;

  state_t         state;
  logic [31:0]    end_reg;
  logic [255:0]   target_reg;
  logic [255:0]   digest_reg;
  logic           hit;
  logic           can_start;
  logic           wdog_expire;

  if (WDOG_CYCLES < 1) begin : g_wdog_range_check
    $error("WDOG_CYCLES must be at least 1");
  end

  assign hit       = digest_reg < target_reg;
  assign can_start = start && !stop &&
                     (state == IDLE || state == FOUND || state == EXHAUSTED);

  // Outputs are pure decodes of the state register.
  assign hash_enable = (state == LAUNCH);
  assign busy        = (state == LAUNCH) || (state == WAIT) || (state == CHECK);
  assign found       = (state == FOUND);
  assign done        = (state == FOUND) || (state == EXHAUSTED);

`ifdef MINER_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;

  // Counter holds at zero outside WAIT, so every entry into WAIT starts fresh.
  assign wdog_expire = (state == WAIT) && !finished &&
                       (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      retries  <= 8'd0;
    end else begin
      wdog_cnt <= (state == WAIT && !wdog_expire) ? wdog_cnt + 1'b1 : '0;
      if (can_start)
        retries <= 8'd0;
      else if (wdog_expire && !stop && retries != 8'hFF)
        retries <= retries + 8'd1;
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign retries     = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      nonce       <= 32'd0;
      end_reg     <= 32'd0;
      target_reg  <= '0;
      digest_reg  <= '0;
      found_nonce <= 32'd0;
      hash_count  <= 32'd0;
    end else if (stop) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (start) begin
            state      <= LAUNCH;
            nonce      <= nonce_start;
            end_reg    <= nonce_end;
            target_reg <= target;
            hash_count <= 32'd0;
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (finished) begin
            digest_reg <= digest;
            state      <= CHECK;
          end else if (wdog_expire) begin
            state <= LAUNCH;
          end
        end
        CHECK: begin
          hash_count <= hash_count + 32'd1;
          if (hit) begin
            found_nonce <= nonce;
            state       <= FOUND;
          end else if (nonce == end_reg) begin
            state <= EXHAUSTED;
          end else begin
            nonce <= nonce + 32'd1;
            state <= LAUNCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
